// File: rtl/cmm4_stream_sequencer_pkg.sv
// Shared types and constants for the 4x4 complex matrix stream sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default element width, result width helper, FSM state enum,
// frame/matrix sizes and row/col-from-index helpers (row-major, 4 columns).
package cmm4_pkg;

  localparam int DEF_W     = 32;
  localparam int FRAME_LEN = 32;   // 16 A elements followed by 16 B elements
  localparam int MAT_ELEMS = 16;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Result width: a W x W product is 2W bits, a complex term adds one bit,
  // and the 4-term dot product adds two more.
  function automatic int cw_for(input int w);
    return 2 * w + 3;
  endfunction

  function automatic logic [1:0] idx_row(input logic [3:0] idx);
    return idx[3:2];
  endfunction

  function automatic logic [1:0] idx_col(input logic [3:0] idx);
    return idx[1:0];
  endfunction

endpackage

// File: rtl/cmm4_stream_sequencer_if.sv
// Valid/ready stream interfaces for the sequencer's element input and result output.
// Latency: n/a (wiring only).
// Backpressure: an element moves only on a cycle where valid && ready.
// cmm4_in_if : valid, ready, re, im, last (marks element 31 of a frame)
// cmm4_out_if: valid, ready, re, im, idx (row-major 4*row+col), last (idx 15)
interface cmm4_in_if #(
  parameter int W = 32
);
  logic         valid;
  logic         ready;
  logic [W-1:0] re;
  logic [W-1:0] im;
  logic         last;

  modport master (output valid, re, im, last, input ready);
  modport slave  (input valid, re, im, last, output ready);
endinterface

interface cmm4_out_if #(
  parameter int CW = 67
);
  logic          valid;
  logic          ready;
  logic [CW-1:0] re;
  logic [CW-1:0] im;
  logic [3:0]    idx;
  logic          last;

  modport master (output valid, re, im, idx, last, input ready);
  modport slave  (input valid, re, im, idx, last, output ready);
endinterface

// File: rtl/cmm4_stream_sequencer.sv
// Deserializes a 32-element frame into operand matrices A/B, waits for the external multiplier, serializes 16 results.
// Latency: last input accept at edge T -> first out_valid in cycle T+MUL_LAT+1.
// Backpressure: in_ready low in WAIT/DRAIN; output data held while out_valid && !out_ready.
// Ports: clk, rst_n (async active-low); in_s element stream; out_m result stream;
// mA/mB operand registers to the multiplier; mC combinational results back; busy; err_frame pulse.
module cmm4_stream_sequencer
  import cmm4_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int CW      = cw_for(W),
  parameter int MUL_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cmm4_in_if.slave                 in_s,
  cmm4_out_if.master               out_m,
  output logic [3:0][3:0][W-1:0]   mA_re,
  output logic [3:0][3:0][W-1:0]   mA_im,
  output logic [3:0][3:0][W-1:0]   mB_re,
  output logic [3:0][3:0][W-1:0]   mB_im,
  input  logic [3:0][3:0][CW-1:0]  mC_re,
  input  logic [3:0][3:0][CW-1:0]  mC_im,
  output logic                     busy,
  output logic                     err_frame
);

  state_t                   state, state_nxt;
  logic [4:0]               cnt;
  logic [15:0]              wcnt;
  logic [3:0]               ocnt;
  logic [3:0][3:0][CW-1:0]  res_re, res_im;
  logic                     in_rdy_q;
  logic                     err_q;

  logic in_acc, out_acc, frame_end, early_last, capture;

  // in_rdy_q is registered from the next state, so it is low during reset and
  // for the first cycle after release, and is only ever high while in LOAD.
  assign in_acc     = in_s.valid && in_rdy_q;
  assign frame_end  = in_acc && (cnt == 5'(FRAME_LEN - 1));
  assign early_last = in_acc && in_s.last && (cnt != 5'(FRAME_LEN - 1));
  assign capture    = (state == WAIT) && (wcnt == 16'(MUL_LAT - 1));
  assign out_acc    = (state == DRAIN) && out_m.ready;

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (frame_end) state_nxt = WAIT;
      WAIT:    if (capture) state_nxt = DRAIN;
      DRAIN:   if (out_acc && (ocnt == 4'(MAT_ELEMS - 1))) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      cnt      <= '0;
      wcnt     <= '0;
      ocnt     <= '0;
      in_rdy_q <= 1'b0;
      err_q    <= 1'b0;
      mA_re    <= '0;
      mA_im    <= '0;
      mB_re    <= '0;
      mB_im    <= '0;
      res_re   <= '0;
      res_im   <= '0;
    end else begin
      state    <= state_nxt;
      in_rdy_q <= (state_nxt == LOAD);
      // Early in_last drops the element; a missing in_last on element 31 is
      // flagged but the frame still completes on count alone.
      err_q    <= early_last || (frame_end && !in_s.last);

      if (in_acc) begin
        if (early_last || frame_end) cnt <= '0;
        else                         cnt <= cnt + 5'd1;
      end

      if (in_acc && !early_last) begin
        if (!cnt[4]) begin
          mA_re[idx_row(cnt[3:0])][idx_col(cnt[3:0])] <= in_s.re;
          mA_im[idx_row(cnt[3:0])][idx_col(cnt[3:0])] <= in_s.im;
        end else begin
          mB_re[idx_row(cnt[3:0])][idx_col(cnt[3:0])] <= in_s.re;
          mB_im[idx_row(cnt[3:0])][idx_col(cnt[3:0])] <= in_s.im;
        end
      end

      if (state == WAIT) wcnt <= capture ? '0 : wcnt + 16'd1;

      if (capture) begin
        res_re <= mC_re;
        res_im <= mC_im;
      end

      // Wraps to 0 on the final handshake, ready for the next frame.
      if (out_acc) ocnt <= ocnt + 4'd1;
    end
  end

  assign in_s.ready  = in_rdy_q;
  assign out_m.valid = (state == DRAIN);
  assign out_m.re    = res_re[idx_row(ocnt)][idx_col(ocnt)];
  assign out_m.im    = res_im[idx_row(ocnt)][idx_col(ocnt)];
  assign out_m.idx   = ocnt;
  assign out_m.last  = (state == DRAIN) && (ocnt == 4'(MAT_ELEMS - 1));
  assign busy        = (state != LOAD);
  assign err_frame   = err_q;

endmodule
